// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined processor front end.
// Holds the instruction width, the fetch FSM state encoding and the
// default values for the reset PC and the HALT opcode.
package cpu_pkg;
  localparam int          INSTR_W      = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [4:0]  OPC_HALT_DEF = 5'b00000;

  typedef enum logic {
    FETCH_S = 1'b0,
    HALT_S  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   req   : fetch request (fetch -> mem)
//   addr  : fetch address (fetch -> mem)
//   ready : memory accepts req and returns rdata in the same cycle
//   rdata : instruction word (mem -> fetch)
interface fetch_stage_if;
  import cpu_pkg::*;
  logic               req;
  logic [15:0]        addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input  ready, rdata);
  modport slave  (input  req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_stage_pc_incr.sv
// PC+2 incrementer built on a two-level 16-bit carry-lookahead adder.
//   carry_lookahead16 : inA + inB + Cin -> S, Cout
//   pc_incr           : pc -> pc_plus2 (wraps at 16 bits)
module carry_lookahead16 (
  input  logic [15:0] inA,
  input  logic [15:0] inB,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  cg;

  assign g = inA & inB;
  assign p = inA ^ inB;

  // Group generate/propagate per 4-bit slice, then lookahead across slices.
  always_comb begin
    cg[0] = Cin;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
              (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
  end

  // In-slice carries only need the slice carry-in.
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cg[k];
      for (int i = 1; i < 4; i++)
        c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
    end
  end

  assign S    = p ^ c;
  assign Cout = cg[4];
endmodule

module pc_incr (
  input  logic [15:0] pc,
  output logic [15:0] pc_plus2
);
  logic cout_unused;

  carry_lookahead16 u_cla (
    .inA  (pc),
    .inB  (16'h0002),
    .Cin  (1'b0),
    .S    (pc_plus2),
    .Cout (cout_unused)
  );
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID latch with the fetched word and its PC+2.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   stall                 : hold PC and IF/ID latch, no request
//   redirect_valid/target : taken branch/jump from decode
//   imem (master)         : req/addr out, ready/rdata in
//   id_valid/instr/pc_next: IF/ID latch
//   misalign_err          : one-cycle pulse on odd redirect target
//   halted                : high while in HALT
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [4:0]  OPC_HALT = OPC_HALT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_target,
  fetch_stage_if.master      imem,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [15:0]        id_pc_next,
  output logic               misalign_err,
  output logic               halted
);
  fetch_state_e       state_q, state_d;
  logic [15:0]        pc_q, pc_d, pc_plus2;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [15:0]        id_pc_next_q, id_pc_next_d;
  logic               misalign_q, misalign_d;
  logic               halted_q, halted_d;

  pc_incr u_pc_incr (.pc(pc_q), .pc_plus2(pc_plus2));

  assign imem.req  = (state_q == FETCH_S) & ~stall;
  assign imem.addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_next_d = id_pc_next_q;
    misalign_d   = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over stall; any same-cycle rdata is wrong-path.
      pc_d       = {redirect_target[15:1], 1'b0};
      id_valid_d = 1'b0;
      state_d    = FETCH_S;
      misalign_d = redirect_target[0];
    end else if (stall) begin
      // hold everything
    end else if (state_q == HALT_S) begin
      id_valid_d = 1'b0;
    end else if (imem.ready) begin
      pc_d         = pc_plus2;
      id_instr_d   = imem.rdata;
      id_pc_next_d = pc_plus2;
      id_valid_d   = 1'b1;
      if (imem.rdata[15:11] == OPC_HALT) state_d = HALT_S;
    end else begin
      id_valid_d = 1'b0;  // wait state -> bubble
    end
    halted_d = (state_d == HALT_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_S;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_next_q <= '0;
      misalign_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_next_q <= id_pc_next_d;
      misalign_q   <= misalign_d;
      halted_q     <= halted_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc_next   = id_pc_next_q;
  assign misalign_err = misalign_q;
  assign halted       = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change just after the falling
// edge, registered outputs are checked at the following falling edge.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid;
  logic [15:0] redirect_target;
  logic        id_valid, misalign_err, halted;
  logic [15:0] id_instr, id_pc_next;
  int          checks = 0;
  int          failures = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (imem.master),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc_next      (id_pc_next),
    .misalign_err    (misalign_err),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem.ready = 1'b0; imem.rdata = '0;
    #12;
    chk("rst_id_valid", {15'b0, id_valid}, 16'h0);
    chk("rst_id_instr", id_instr, 16'h0000);
    chk("rst_id_pc_next", id_pc_next, 16'h0000);
    chk("rst_misalign", {15'b0, misalign_err}, 16'h0);
    chk("rst_halted", {15'b0, halted}, 16'h0);
    chk("rst_addr", imem.addr, 16'h0000);

    // Zero-wait streaming
    cyc(); rst_n = 1'b1;
    imem.ready = 1'b1; imem.rdata = 16'h4000;
    #1 chk("first_req", {15'b0, imem.req}, 16'h1);
    chk("first_addr", imem.addr, 16'h0000);
    cyc();
    chk("s0_valid", {15'b0, id_valid}, 16'h1);
    chk("s0_instr", id_instr, 16'h4000);
    chk("s0_pcn", id_pc_next, 16'h0002);
    chk("s0_addr", imem.addr, 16'h0002);
    imem.rdata = 16'h4001; cyc();
    chk("s1_valid", {15'b0, id_valid}, 16'h1);
    chk("s1_instr", id_instr, 16'h4001);
    chk("s1_pcn", id_pc_next, 16'h0004);
    chk("s1_addr", imem.addr, 16'h0004);
    imem.rdata = 16'h4002; cyc();
    chk("s2_valid", {15'b0, id_valid}, 16'h1);
    chk("s2_pcn", id_pc_next, 16'h0006);
    chk("s2_addr", imem.addr, 16'h0006);

    // Redirect to 0x0010; same-cycle rdata is discarded
    redirect_valid = 1'b1; redirect_target = 16'h0010; imem.rdata = 16'h4003; cyc();
    redirect_valid = 1'b0;
    chk("rd10_valid", {15'b0, id_valid}, 16'h0);
    chk("rd10_addr", imem.addr, 16'h0010);
    chk("rd10_instr_hold", id_instr, 16'h4002);
    chk("rd10_misalign", {15'b0, misalign_err}, 16'h0);

    // Three wait states
    imem.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_valid", {15'b0, id_valid}, 16'h0);
      chk("wait_addr", imem.addr, 16'h0010);
      chk("wait_pcn_hold", id_pc_next, 16'h0006);
    end
    imem.ready = 1'b1; imem.rdata = 16'h1234; cyc();
    chk("after_wait_valid", {15'b0, id_valid}, 16'h1);
    chk("after_wait_instr", id_instr, 16'h1234);
    chk("after_wait_pcn", id_pc_next, 16'h0012);
    chk("after_wait_addr", imem.addr, 16'h0012);

    // Two stall cycles with ready high
    stall = 1'b1; imem.rdata = 16'h5555;
    #1 chk("stall_req", {15'b0, imem.req}, 16'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_addr", imem.addr, 16'h0012);
      chk("stall_valid", {15'b0, id_valid}, 16'h1);
      chk("stall_instr", id_instr, 16'h1234);
      chk("stall_pcn", id_pc_next, 16'h0012);
    end
    stall = 1'b0; imem.rdata = 16'h5678;
    #1 chk("resume_req", {15'b0, imem.req}, 16'h1);
    cyc();
    chk("resume_instr", id_instr, 16'h5678);
    chk("resume_pcn", id_pc_next, 16'h0014);
    chk("resume_addr", imem.addr, 16'h0014);

    // Misaligned redirect while stalled
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0101; cyc();
    chk("mis_addr", imem.addr, 16'h0100);
    chk("mis_valid", {15'b0, id_valid}, 16'h0);
    chk("mis_err", {15'b0, misalign_err}, 16'h1);
    stall = 1'b0; redirect_valid = 1'b0; imem.ready = 1'b0; cyc();
    chk("mis_err_pulse", {15'b0, misalign_err}, 16'h0);
    chk("mis_addr_hold", imem.addr, 16'h0100);

    // HALT at 0x0020
    redirect_valid = 1'b1; redirect_target = 16'h0020; cyc();
    redirect_valid = 1'b0;
    chk("h_addr", imem.addr, 16'h0020);
    imem.ready = 1'b1; imem.rdata = 16'h0000; cyc();
    chk("h_valid", {15'b0, id_valid}, 16'h1);
    chk("h_instr", id_instr, 16'h0000);
    chk("h_pcn", id_pc_next, 16'h0022);
    chk("h_halted", {15'b0, halted}, 16'h1);
    chk("h_req", {15'b0, imem.req}, 16'h0);
    imem.rdata = 16'h4444; cyc();
    chk("h2_valid", {15'b0, id_valid}, 16'h0);
    chk("h2_halted", {15'b0, halted}, 16'h1);
    chk("h2_addr", imem.addr, 16'h0022);
    redirect_valid = 1'b1; redirect_target = 16'h0040; cyc();
    redirect_valid = 1'b0;
    chk("hr_halted", {15'b0, halted}, 16'h0);
    chk("hr_addr", imem.addr, 16'h0040);
    chk("hr_req", {15'b0, imem.req}, 16'h1);
    imem.rdata = 16'h4100; cyc();
    chk("hr_instr", id_instr, 16'h4100);
    chk("hr_pcn", id_pc_next, 16'h0042);

    // PC wrap
    redirect_valid = 1'b1; redirect_target = 16'hFFFE; cyc();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem.addr, 16'hFFFE);
    imem.rdata = 16'h4200; cyc();
    chk("wrap_addr", imem.addr, 16'h0000);
    chk("wrap_pcn", id_pc_next, 16'h0000);
    chk("wrap_instr", id_instr, 16'h4200);

    // Async reset in the middle of a wait state
    redirect_valid = 1'b1; redirect_target = 16'h0031; imem.ready = 1'b0; cyc();
    redirect_valid = 1'b0;
    chk("pre_rst_addr", imem.addr, 16'h0030);
    chk("pre_rst_err", {15'b0, misalign_err}, 16'h1);
    #2 rst_n = 1'b0; imem.ready = 1'b1; imem.rdata = 16'h4300;
    #1;
    chk("arst_addr", imem.addr, 16'h0000);
    chk("arst_valid", {15'b0, id_valid}, 16'h0);
    chk("arst_instr", id_instr, 16'h0000);
    chk("arst_pcn", id_pc_next, 16'h0000);
    chk("arst_err", {15'b0, misalign_err}, 16'h0);
    chk("arst_halted", {15'b0, halted}, 16'h0);
    cyc(); cyc();
    chk("arst_hold_valid", {15'b0, id_valid}, 16'h0);
    rst_n = 1'b1; imem.rdata = 16'h4500;
    #1 chk("rel_req", {15'b0, imem.req}, 16'h1);
    cyc();
    chk("rel_instr", id_instr, 16'h4500);
    chk("rel_pcn", id_pc_next, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
